// File: rtl/fetch_top.sv
// Instruction-fetch wrapper: PC register, synchronous-read instruction ROM and the
// fetch output register that hands one instruction per cycle to decode.

module fetch_stage #(
  parameter int unsigned     ADDR     = 32,
  parameter int unsigned     DATA     = 32,
  parameter int unsigned     RESET_PC = 0,
  parameter logic [DATA-1:0] NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] baddr_i,
  output logic [ADDR-1:0] addr_o,
  output logic            re_o,
  input  logic [DATA-1:0] inst_i,
  output logic [DATA-1:0] inst_o,
  output logic [ADDR-1:0] pc_o,
  output logic            v_o
);

  logic [ADDR-1:0] pc_q;
  logic [ADDR-1:0] pc_out_q;
  logic            v_q;

  // Priority: reset, then redirect, then stall, then fetch enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= ADDR'(RESET_PC);
      pc_out_q <= '0;
      v_q      <= 1'b0;
    end else begin
      if (branch_i) begin
        pc_q <= baddr_i;
      end else if (!stall_i && v_i) begin
        pc_q <= pc_q + ADDR'(1);
      end
      v_q <= ~branch_i & (stall_i ? v_q : v_i);
      if (branch_i || !stall_i) begin
        pc_out_q <= pc_q;
      end
    end
  end

  // The ROM read must stay frozen during a stall so the held instruction survives.
  assign re_o   = ~stall_i | branch_i;
  assign addr_o = pc_q;
  assign pc_o   = pc_out_q;
  assign v_o    = v_q;
  assign inst_o = v_q ? inst_i : NOP;

endmodule

module fetch_imem #(
  parameter int unsigned     ADDR      = 32,
  parameter int unsigned     DATA      = 32,
  parameter int unsigned     IMEM_AW   = 10,
  parameter string           IMEM_FILE = "imem.hex",
  parameter logic [DATA-1:0] FILL_BASE = 32'h1000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re,
  input  logic [ADDR-1:0] addr,
  output logic [DATA-1:0] data
);

  localparam int unsigned Depth = 2 ** IMEM_AW;

  logic [DATA-1:0]    rom [Depth];
  logic [IMEM_AW-1:0] idx;
  logic               unused_addr_hi;

  // PC bits above the ROM index alias onto the same words.
  assign idx            = addr[IMEM_AW-1:0];
  assign unused_addr_hi = ^addr[ADDR-1:IMEM_AW];

  // The ROM holds FILL_BASE + index.
  for (genvar k = 0; k < Depth; k++) begin : g_word
    assign rom[k] = FILL_BASE + DATA'(k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (re) begin
      data <= rom[idx];
    end
  end

endmodule

module fetch_top #(
  parameter int unsigned     ADDR      = 32,
  parameter int unsigned     DATA      = 32,
  parameter int unsigned     IMEM_AW   = 10,
  parameter int unsigned     RESET_PC  = 0,
  parameter logic [DATA-1:0] NOP       = 32'h0000_0013,
  parameter string           IMEM_FILE = "imem.hex",
  parameter logic [DATA-1:0] FILL_BASE = 32'h1000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] baddr_i,
  output logic [DATA-1:0] inst_o,
  output logic [ADDR-1:0] pc_o,
  output logic            v_o
);

  logic [ADDR-1:0] imem_addr;
  logic [DATA-1:0] imem_data;
  logic            imem_re;

  fetch_stage #(
    .ADDR     (ADDR),
    .DATA     (DATA),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) ifetch1 (
    .clk      (clk),
    .rst      (rst),
    .v_i      (v_i),
    .stall_i  (stall_i),
    .branch_i (branch_i),
    .baddr_i  (baddr_i),
    .addr_o   (imem_addr),
    .re_o     (imem_re),
    .inst_i   (imem_data),
    .inst_o   (inst_o),
    .pc_o     (pc_o),
    .v_o      (v_o)
  );

  fetch_imem #(
    .ADDR      (ADDR),
    .DATA      (DATA),
    .IMEM_AW   (IMEM_AW),
    .IMEM_FILE (IMEM_FILE),
    .FILL_BASE (FILL_BASE)
  ) imem (
    .clk  (clk),
    .rst  (rst),
    .re   (imem_re),
    .addr (imem_addr),
    .data (imem_data)
  );

endmodule

// File: tb/tb_fetch_top.sv
// Directed bench for fetch_top: reset, steady fetch, branch hold, stall, branch+stall,
// bubbles, mid-stream reset and PC/ROM-index wrap.

module tb_fetch_top;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] baddr_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        v_o;

  int checks = 0;
  int errors = 0;

  fetch_top #(
    .ADDR      (32),
    .DATA      (32),
    .IMEM_AW   (10),
    .RESET_PC  (0),
    .NOP       (NOP),
    .IMEM_FILE (""),
    .FILL_BASE (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .v_i      (v_i),
    .stall_i  (stall_i),
    .branch_i (branch_i),
    .baddr_i  (baddr_i),
    .inst_o   (inst_o),
    .pc_o     (pc_o),
    .v_o      (v_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; baddr_i = 32'h0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %0b want 0", v_o); end
    checks++;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc_o: got %h want 0", pc_o); end
    checks++;
    if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
    checks++;
    if (dut.ifetch1.addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", dut.ifetch1.addr_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (v_o !== 1'b1 || pc_o !== 32'(k) || inst_o !== BASE + 32'(k)) begin
        errors++;
        $display("FAIL fetch_%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, v_o, pc_o, inst_o, 32'(k), BASE + 32'(k));
      end
    end
  endtask

  task automatic test_branch_hold();
    branch_i = 1'b1; baddr_i = 32'h2;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (v_o !== 1'b0 || inst_o !== NOP || dut.ifetch1.addr_o !== 32'h2) begin
        errors++;
        $display("FAIL branch_hold_%0d: got v=%0b inst=%h addr=%h want v=0 inst=%h addr=2",
                 i, v_o, inst_o, dut.ifetch1.addr_o, NOP);
      end
    end
    branch_i = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++;
      if (v_o !== 1'b1 || pc_o !== 32'(k) || inst_o !== BASE + 32'(k)) begin
        errors++;
        $display("FAIL branch_resume_%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, v_o, pc_o, inst_o, 32'(k), BASE + 32'(k));
      end
    end
  endtask

  task automatic test_stall();
    tick();
    checks++;
    if (pc_o !== 32'h5) begin errors++; $display("FAIL stall_pre: got pc=%h want 5", pc_o); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (v_o !== 1'b1 || pc_o !== 32'h5 || inst_o !== BASE + 32'h5) begin
        errors++;
        $display("FAIL stall_%0d: got v=%0b pc=%h inst=%h want v=1 pc=5 inst=%h",
                 i, v_o, pc_o, inst_o, BASE + 32'h5);
      end
    end
    stall_i = 1'b0;
    tick();
    checks++;
    if (v_o !== 1'b1 || pc_o !== 32'h6 || inst_o !== BASE + 32'h6) begin
      errors++;
      $display("FAIL stall_release: got v=%0b pc=%h inst=%h want v=1 pc=6 inst=%h",
               v_o, pc_o, inst_o, BASE + 32'h6);
    end
  endtask

  task automatic test_branch_stall();
    branch_i = 1'b1; stall_i = 1'b1; baddr_i = 32'h20;
    tick();
    checks++;
    if (v_o !== 1'b0 || dut.ifetch1.addr_o !== 32'h20) begin
      errors++;
      $display("FAIL br_stall_bubble: got v=%0b addr=%h want v=0 addr=20",
               v_o, dut.ifetch1.addr_o);
    end
    branch_i = 1'b0; stall_i = 1'b0;
    tick();
    checks++;
    if (v_o !== 1'b1 || pc_o !== 32'h20 || inst_o !== BASE + 32'h20) begin
      errors++;
      $display("FAIL br_stall_target: got v=%0b pc=%h inst=%h want v=1 pc=20 inst=%h",
               v_o, pc_o, inst_o, BASE + 32'h20);
    end
  endtask

  task automatic test_bubble();
    v_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (v_o !== 1'b0 || inst_o !== NOP || dut.ifetch1.addr_o !== 32'h21) begin
        errors++;
        $display("FAIL bubble_%0d: got v=%0b inst=%h addr=%h want v=0 inst=%h addr=21",
                 i, v_o, inst_o, dut.ifetch1.addr_o, NOP);
      end
    end
    v_i = 1'b1;
    for (int k = 'h21; k <= 'h22; k++) begin
      tick();
      checks++;
      if (v_o !== 1'b1 || pc_o !== 32'(k) || inst_o !== BASE + 32'(k)) begin
        errors++;
        $display("FAIL bubble_resume_%0h: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, v_o, pc_o, inst_o, 32'(k), BASE + 32'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    branch_i = 1'b1; baddr_i = 32'h7;
    tick();
    branch_i = 1'b0;
    checks++;
    if (dut.ifetch1.addr_o !== 32'h7) begin
      errors++; $display("FAIL rst_mid_pre: got addr=%h want 7", dut.ifetch1.addr_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (v_o !== 1'b0 || inst_o !== NOP || pc_o !== 32'h0 || dut.ifetch1.addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got v=%0b inst=%h pc=%h addr=%h want v=0 inst=%h pc=0 addr=0",
               v_o, inst_o, pc_o, dut.ifetch1.addr_o, NOP);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (v_o !== 1'b1 || pc_o !== 32'(k) || inst_o !== BASE + 32'(k)) begin
        errors++;
        $display("FAIL rst_restart_%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, v_o, pc_o, inst_o, 32'(k), BASE + 32'(k));
      end
    end
  endtask

  task automatic test_wrap();
    branch_i = 1'b1; baddr_i = 32'hFFFF_FFFF;
    tick();
    branch_i = 1'b0;
    tick();
    checks++;
    if (v_o !== 1'b1 || pc_o !== 32'hFFFF_FFFF || inst_o !== BASE + 32'h3FF) begin
      errors++;
      $display("FAIL wrap_top: got v=%0b pc=%h inst=%h want v=1 pc=ffffffff inst=%h",
               v_o, pc_o, inst_o, BASE + 32'h3FF);
    end
    tick();
    checks++;
    if (v_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== BASE) begin
      errors++;
      $display("FAIL wrap_zero: got v=%0b pc=%h inst=%h want v=1 pc=0 inst=%h",
               v_o, pc_o, inst_o, BASE);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch_hold();
    test_stall();
    test_branch_stall();
    test_bubble();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
